// File: rtl/seripara_rx_ctrl.sv
// seripara_rx_ctrl
//   Frame-level receive controller around a serial-in/parallel-out shift
//   register. The controller waits for a start bit and then shifts in W data
//   bits, MSB first. It checks the stop bit and presents each completed word
//   on a valid/ready port. It also flags framing errors and overruns.
//
// Parameters
//   W        data bits per frame (2..16)
//   IDLE_LV  line idle level; start bit = ~IDLE_LV, stop bit = IDLE_LV
//
// Ports
//   clk        in   system clock, all state on posedge
//   res        in   asynchronous, active-high reset
//   ena        in   bit strobe; si is sampled only on edges with ena=1
//   si         in   serial data line
//   q          out  received word, held stable while valid=1
//   valid      out  q holds an unconsumed word
//   ready      in   consumer accepts q on an edge with valid&ready
//   ferr       out  one-cycle pulse: bad stop bit, frame discarded
//   ovr        out  sticky: a good frame was dropped because valid was still 1
//   clr        in   synchronous clear of ovr (and perr); a same-edge set wins
//   perr       out  (SERIPARA_PARITY_EN only) sticky even-parity mismatch
//   dbg_state  out  current FSM state (0 IDLE, 1 DATA, 2 PAR, 3 STOP)
//
// Handshake: q is offered while valid=1. It is consumed on a rising edge
// where valid and ready are both 1. ready is ignored while valid=0. A good
// frame that completes on the consuming edge replaces q, and valid stays 1.
//
// Optional feature macro: SERIPARA_PARITY_EN. This adds a PAR state that
// samples an even-parity bit after the data bits, and adds the perr output.

module seripara_rx_ctrl #(
    parameter int W       = 4,
    parameter int IDLE_LV = 1
) (
    input  logic         clk,
    input  logic         res,
    input  logic         ena,
    input  logic         si,
    output logic [W-1:0] q,
    output logic         valid,
    input  logic         ready,
    output logic         ferr,
    output logic         ovr,
    input  logic         clr,
`ifdef SERIPARA_PARITY_EN
    output logic         perr,
`endif
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_PAR  = 2'd2,
        S_STOP = 2'd3
    } state_t;

    localparam int            CW       = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    localparam logic          IDLE_BIT = (IDLE_LV != 0) ? 1'b1 : 1'b0;

    state_t        state, state_n;
    logic [W-1:0]  sr, sr_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [W-1:0]  q_n;
    logic          valid_n, ferr_n, ovr_n;
`ifdef SERIPARA_PARITY_EN
    logic          perr_n;
`endif

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state <= S_IDLE;
            sr    <= '0;
            cnt   <= '0;
            q     <= '0;
            valid <= 1'b0;
            ferr  <= 1'b0;
            ovr   <= 1'b0;
`ifdef SERIPARA_PARITY_EN
            perr  <= 1'b0;
`endif
        end else begin
            state <= state_n;
            sr    <= sr_n;
            cnt   <= cnt_n;
            q     <= q_n;
            valid <= valid_n;
            ferr  <= ferr_n;
            ovr   <= ovr_n;
`ifdef SERIPARA_PARITY_EN
            perr  <= perr_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        sr_n    = sr;
        cnt_n   = cnt;
        q_n     = q;
        valid_n = valid;
        ferr_n  = 1'b0;
        ovr_n   = ovr;
`ifdef SERIPARA_PARITY_EN
        perr_n  = perr;
`endif

        // The consumer handshake runs on every edge, strobe or not.
        if (valid && ready) valid_n = 1'b0;

        // The clear is applied first so that a set later in this block wins.
        if (clr) begin
            ovr_n = 1'b0;
`ifdef SERIPARA_PARITY_EN
            perr_n = 1'b0;
`endif
        end

        if (ena) begin
            case (state)
                S_IDLE: begin
                    if (si != IDLE_BIT) begin
                        state_n = S_DATA;
                        cnt_n   = '0;
                    end
                end
                S_DATA: begin
                    sr_n  = {sr[W-2:0], si};
                    cnt_n = cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        cnt_n = '0;
`ifdef SERIPARA_PARITY_EN
                        state_n = S_PAR;
`else
                        state_n = S_STOP;
`endif
                    end
                end
`ifdef SERIPARA_PARITY_EN
                S_PAR: begin
                    // Even parity: the data bits XOR the parity bit must be 0.
                    // A mismatch is only flagged; the word is still delivered.
                    if ((^sr ^ si) != 1'b0) perr_n = 1'b1;
                    state_n = S_STOP;
                end
`endif
                S_STOP: begin
                    if (si == IDLE_BIT) begin
                        if (!valid || ready) begin
                            q_n     = sr;
                            valid_n = 1'b1;
                        end else begin
                            ovr_n = 1'b1;
                        end
                    end else begin
                        ferr_n = 1'b1;
                    end
                    // The stop sample is never reused as a start bit.
                    state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_seripara_rx_ctrl.sv
module tb_seripara_rx_ctrl;

    localparam int W = 4;
    localparam int EV_NONE = 0;
    localparam int EV_GOOD = 1;
    localparam int EV_BAD  = 2;
    localparam int EV_PAR  = 3;

    // clock / reset
    logic clk = 1'b0;
    logic res = 1'b1;
    always #5 clk = ~clk;

    logic         ena = 1'b0;
    logic         si = 1'b1;
    logic         ready = 1'b0;
    logic         clr = 1'b0;
    logic [W-1:0] q;
    logic         valid, ferr, ovr;
    logic [1:0]   dbg_state;
`ifdef SERIPARA_PARITY_EN
    logic         perr;
`endif

    seripara_rx_ctrl #(.W(W), .IDLE_LV(1)) dut (
        .clk(clk), .res(res), .ena(ena), .si(si),
        .q(q), .valid(valid), .ready(ready),
        .ferr(ferr), .ovr(ovr), .clr(clr),
`ifdef SERIPARA_PARITY_EN
        .perr(perr),
`endif
        .dbg_state(dbg_state)
    );

    // reference model: word-level view of the port contract
    logic [W-1:0] m_q = '0;
    logic         m_valid = 1'b0;
    logic         m_ovr = 1'b0;
    logic         m_perr = 1'b0;
    logic         m_ferr = 1'b0;
    logic [W-1:0] exp_q[$];

    int n_pass = 0;
    int n_total = 0;
    int rdy_mode = 0;      // 0 low, 1 high, 2 random
    int rdy_override = -1; // forced ready on the next strobe edge
    int gap_mode = 0;      // ena=0 cycles before each strobe: 0 none, 1 one, 2 random
    int clr_pct = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic model_reset();
        m_q = '0; m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
        exp_q.delete();
    endtask

    // driver: one clock edge with given ena/si; ready and clr come from the modes
    task automatic step(input logic e, input logic s, input int ev, input logic [W-1:0] d);
        logic r, c, acc, nv;
        logic [W-1:0] acc_q;
        r = (rdy_mode == 0) ? 1'b0 : (rdy_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        if (e && rdy_override >= 0) r = (rdy_override != 0);
        c = ($urandom_range(0, 99) < clr_pct);
        ena = e; si = s; ready = r; clr = c;
        acc = valid & ready;
        acc_q = q;
        @(posedge clk);
        m_ferr = 1'b0;
        nv = m_valid && !r;
        if (c) begin
            m_ovr = 1'b0;
            m_perr = 1'b0;
        end
        if (e) begin
            case (ev)
                EV_GOOD: begin
                    if (!m_valid || r) begin
                        m_q = d;
                        nv = 1'b1;
                        exp_q.push_back(d);
                    end else begin
                        m_ovr = 1'b1;
                    end
                end
                EV_BAD: m_ferr = 1'b1;
                EV_PAR: if (d[0]) m_perr = 1'b1;
                default: ;
            endcase
        end
        m_valid = nv;
        #1;
        if (acc) begin
            if (exp_q.size() == 0) chk("accept_unexpected", 1, 0);
            else chk("accept_q", 32'(acc_q), 32'(exp_q.pop_front()));
        end
        chk("valid", 32'(valid), 32'(m_valid));
        chk("q", 32'(q), 32'(m_q));
        chk("ferr", 32'(ferr), 32'(m_ferr));
        chk("ovr", 32'(ovr), 32'(m_ovr));
`ifdef SERIPARA_PARITY_EN
        chk("perr", 32'(perr), 32'(m_perr));
`endif
    endtask

    task automatic strobe(input logic s, input int ev, input logic [W-1:0] d);
        int gaps;
        gaps = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 3));
        for (int i = 0; i < gaps; i++) step(1'b0, 1'($urandom_range(0, 1)), EV_NONE, '0);
        step(1'b1, s, ev, d);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic good_stop,
                              input logic par_bad, input int stop_rdy);
        strobe(1'b0, EV_NONE, '0);
        for (int i = W - 1; i >= 0; i--) strobe(d[i], EV_NONE, '0);
`ifdef SERIPARA_PARITY_EN
        strobe(^d ^ par_bad, EV_PAR, {{(W-1){1'b0}}, par_bad});
`endif
        rdy_override = stop_rdy;
        strobe(good_stop, good_stop ? EV_GOOD : EV_BAD, d);
        rdy_override = -1;
    endtask

    task automatic consume();
        rdy_mode = 1;
        step(1'b1, 1'b1, EV_NONE, '0);
        rdy_mode = 0;
    endtask

    task automatic mid_frame_reset();
        // start bit plus two data bits, then an asynchronous reset
        strobe(1'b0, EV_NONE, '0);
        strobe(1'b1, EV_NONE, '0);
        strobe(1'b1, EV_NONE, '0);
        ena = 1'b0;
        res = 1'b1;
        #2;
        model_reset();
        chk("rst_valid", 32'(valid), 0);
        chk("rst_q", 32'(q), 0);
        chk("rst_ovr", 32'(ovr), 0);
        chk("rst_ferr", 32'(ferr), 0);
        @(posedge clk);
        #1;
        res = 1'b0;
    endtask

    initial begin
        logic [W-1:0] d;
        // reset state
        #12;
        chk("reset_valid", 32'(valid), 0);
        chk("reset_q", 32'(q), 0);
        chk("reset_ferr", 32'(ferr), 0);
        chk("reset_ovr", 32'(ovr), 0);
        @(posedge clk);
        #1;
        res = 1'b0;
        step(1'b1, 1'b1, EV_NONE, '0);
        step(1'b1, 1'b1, EV_NONE, '0);

        // 1: single frame, ready low
        send_frame(4'b1011, 1'b1, 1'b0, -1);
        chk("t1_q", 32'(q), 32'hB);
        chk("t1_valid", 32'(valid), 1);

        // 2: consume, then next frame
        consume();
        chk("t2_valid_cleared", 32'(valid), 0);
        chk("t2_q_held", 32'(q), 32'hB);
        send_frame(4'b0110, 1'b1, 1'b0, -1);
        chk("t2_q", 32'(q), 32'h6);

        // 3: bad stop bit; an immediately following frame must still decode
        send_frame(4'b1111, 1'b0, 1'b0, -1);
        chk("t3_q_kept", 32'(q), 32'h6);
        chk("t3_valid_kept", 32'(valid), 1);
        consume();
        send_frame(4'b1001, 1'b1, 1'b0, -1);
        chk("t3_next_q", 32'(q), 32'h9);

        // 4: overrun, clear, and load on the consuming edge
        consume();
        send_frame(4'b1011, 1'b1, 1'b0, -1);
        send_frame(4'b0001, 1'b1, 1'b0, -1);
        chk("t4_ovr", 32'(ovr), 1);
        chk("t4_q", 32'(q), 32'hB);
        clr_pct = 100;
        step(1'b1, 1'b1, EV_NONE, '0);
        clr_pct = 0;
        chk("t4_clr", 32'(ovr), 0);
        consume();
        send_frame(4'b1011, 1'b1, 1'b0, -1);
        send_frame(4'b0001, 1'b1, 1'b0, 1);
        chk("t4b_q", 32'(q), 32'h1);
        chk("t4b_valid", 32'(valid), 1);
        chk("t4b_ovr", 32'(ovr), 0);

        // 5: mid-frame reset, then clean frame; again with ena toggling
        mid_frame_reset();
        send_frame(4'b0110, 1'b1, 1'b0, -1);
        chk("t5_q", 32'(q), 32'h6);
        gap_mode = 1;
        mid_frame_reset();
        send_frame(4'b0110, 1'b1, 1'b0, -1);
        chk("t5_gap_q", 32'(q), 32'h6);
        gap_mode = 0;

`ifdef SERIPARA_PARITY_EN
        // 6: parity good then bad
        consume();
        send_frame(4'b1011, 1'b1, 1'b0, -1);
        chk("t6_q", 32'(q), 32'hB);
        chk("t6_perr", 32'(perr), 0);
        consume();
        send_frame(4'b1011, 1'b1, 1'b1, -1);
        chk("t6b_q", 32'(q), 32'hB);
        chk("t6b_valid", 32'(valid), 1);
        chk("t6b_perr", 32'(perr), 1);
        clr_pct = 100;
        step(1'b1, 1'b1, EV_NONE, '0);
        clr_pct = 0;
`endif

        // randomized traffic
        rdy_mode = 2;
        gap_mode = 2;
        clr_pct = 5;
        for (int n = 0; n < 150; n++) begin
            d = W'($urandom);
            send_frame(d, ($urandom_range(0, 99) < 85), 1'($urandom_range(0, 1)), -1);
            for (int k = 0; k < int'($urandom_range(0, 2)); k++)
                step(1'b1, 1'b1, EV_NONE, '0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
